// File: rtl/part_buf_deserializer.sv
// Gathers PARTS narrow parts into one WORD_W word. Early termination is via in_last.
// A single output register lets the next word collect while a finished word waits.
module part_buf_deserializer #(
  parameter  int WORD_W    = 32,
  parameter  int PARTS     = 4,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int PART_W    = WORD_W / PARTS,
  localparam int CNT_W     = $clog2(PARTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PART_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  if (PARTS < 2) begin : g_bad_parts
    $error("part_buf_deserializer: PARTS must be >= 2");
  end
  if (WORD_W % PARTS != 0) begin : g_bad_width
    $error("part_buf_deserializer: WORD_W must be a multiple of PARTS");
  end

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PARTS - 1);

  logic [CNT_W-1:0]  cnt_p0;
  logic [WORD_W-1:0] acc_p0;
  logic [WORD_W-1:0] merged;
  logic              slot_free;
  logic              accept;
  logic              complete;

  // Unfilled slots of acc_p0 are always zero, so the merge also zero-fills short words.
  for (genvar k = 0; k < PARTS; k++) begin : g_slot
    localparam int POS = MSB_FIRST ? (PARTS - 1 - k) : k;
    assign merged[POS*PART_W +: PART_W] =
      (cnt_p0 == CNT_W'(k)) ? in_data : acc_p0[POS*PART_W +: PART_W];
  end

  // A completing part needs the output register free or draining this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (((cnt_p0 != LAST_SLOT) && !in_last) || slot_free);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && ((cnt_p0 == LAST_SLOT) || in_last);

  // Stage p0: collection accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (accept) begin
      if (complete) begin
        cnt_p0 <= '0;
        acc_p0 <= '0;
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
        acc_p0 <= merged;
      end
    end
  end

  // Stage p1: held output word
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= merged;
      out_count <= cnt_p0 + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_part_buf_deserializer.sv
// Scoreboard bench for part_buf_deserializer: an LSB-first and an MSB-first instance
// share one stimulus stream; a reference model predicts the words each one must emit.
module tb_part_buf_deserializer;
  localparam int WORD_W = 32;
  localparam int PARTS  = 4;
  localparam int PW     = WORD_W / PARTS;
  localparam int CW     = $clog2(PARTS + 1);

  typedef struct {
    logic [WORD_W-1:0] d;
    logic [CW-1:0]     c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic irl, irm, ovl, ovm;
  logic [WORD_W-1:0] odl, odm;
  logic [CW-1:0] ocl, ocm;

  int nvec = 0;
  int nerr = 0;
  int vhigh = 0;

  logic [PW-1:0] cur[$];
  exp_t exp_l[$];
  exp_t exp_m[$];
  logic held_l = 1'b0, held_m = 1'b0;
  logic [WORD_W-1:0] prev_l, prev_m;

  part_buf_deserializer #(.WORD_W(WORD_W), .PARTS(PARTS), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irl), .in_data(in_data),
    .in_last(in_last), .out_valid(ovl), .out_ready(out_ready), .out_data(odl), .out_count(ocl));

  part_buf_deserializer #(.WORD_W(WORD_W), .PARTS(PARTS), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irm), .in_data(in_data),
    .in_last(in_last), .out_valid(ovm), .out_ready(out_ready), .out_data(odm), .out_count(ocm));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor, hold-stability checks and reference model, all sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [WORD_W-1:0] wl, wm;
    if (ovl && out_ready) begin
      if (exp_l.size() == 0) chk("lsb_unexpected_word", odl, 64'hDEAD);
      else begin
        e = exp_l.pop_front();
        chk("lsb_data", odl, e.d);
        chk("lsb_count", ocl, e.c);
      end
    end
    if (ovm && out_ready) begin
      if (exp_m.size() == 0) chk("msb_unexpected_word", odm, 64'hDEAD);
      else begin
        e = exp_m.pop_front();
        chk("msb_data", odm, e.d);
        chk("msb_count", ocm, e.c);
      end
    end
    if (held_l) begin
      chk("lsb_hold_data", odl, prev_l);
      chk("lsb_hold_valid", ovl, 1);
    end
    if (held_m) begin
      chk("msb_hold_data", odm, prev_m);
      chk("msb_hold_valid", ovm, 1);
    end
    held_l = ovl && !out_ready && !rst;
    held_m = ovm && !out_ready && !rst;
    prev_l = odl;
    prev_m = odm;
    if (ovl) vhigh++;

    if (rst) begin
      cur.delete();
      exp_l.delete();
      exp_m.delete();
    end else if (in_valid && irl) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == PARTS) begin
        wl = '0;
        wm = '0;
        for (int k = 0; k < cur.size(); k++) begin
          wl |= WORD_W'(cur[k]) << (PW * k);
          wm |= WORD_W'(cur[k]) << (PW * (PARTS - 1 - k));
        end
        exp_l.push_back('{d: wl, c: CW'(cur.size())});
        exp_m.push_back('{d: wm, c: CW'(cur.size())});
        cur.delete();
      end
    end
  end

  task automatic send(input logic [PW-1:0] d, input logic l);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!irl && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", irl, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int parts, cyc;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", irl, 0);
    chk("rst_out_valid", ovl, 0);
    chk("rst_out_data", odl, 0);
    chk("rst_out_count", ocl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 1/2: full word, both slot orders, one-cycle valid pulse
    vhigh = 0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("t1_latency_pre", ovl, 0);
    idle();
    @(negedge clk);
    chk("t1_latency", ovl, 1);
    chk("t1_data", odl, 32'h44332211);
    chk("t2_msb_data", odm, 32'h11223344);
    repeat (3) @(negedge clk);
    chk("t1_one_cycle", vhigh, 1);

    // 3: early termination, then in_last on a first part
    send(8'hAA, 0); send(8'hBB, 1);
    send(8'h5C, 1);
    idle();
    repeat (3) @(negedge clk);

    // 4: backpressure across two words
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(PW'(i), 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h08; in_last = 1'b0;
    @(negedge clk);
    chk("t4_ready_drop", irl, 0);
    chk("t4_hold_valid", ovl, 1);
    chk("t4_hold_data", odl, 32'h04030201);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_release", irl, 1);
    idle();
    @(negedge clk);
    chk("t4_second_valid", ovl, 1);
    chk("t4_second_data", odl, 32'h08070605);
    repeat (2) @(negedge clk);

    // 5: reset mid-word
    send(8'h55, 0); send(8'h66, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", irl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_valid", ovl, 0);
    chk("t5_post_data", odl, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    chk("t5_no_early_word", ovl, 0);
    send(8'h04, 0);
    idle();
    @(negedge clk);
    chk("t5_word", odl, 32'h04030201);
    repeat (2) @(negedge clk);

    // 6: random gaps, backpressure and in_last
    parts = 0; cyc = 0; acc = 1'b1;
    while (parts < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = PW'($urandom);
        in_last  = ($urandom_range(0, 5) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && irl;
      if (acc) parts++;
      cyc++;
    end
    chk("t6_parts_accepted", parts, 1000);
    idle();
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_lsb", exp_l.size(), 0);
    chk("drain_msb", exp_m.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/part_buf_deserializer.md
Name: part_buf_deserializer

Overview:
- Receive-side counterpart of the part-buffer serializer.
- Collects PARTS consecutive narrow parts of width WORD_W/PARTS into one WORD_W word.
- Valid/ready on both sides; supports early termination of a word via in_last.
- Sits between a narrow part stream and a wide word consumer.
- Holds one completed word in an output register, so collection of the next word overlaps a stalled output.

Parameters:
- WORD_W, 32, width of the assembled word; must be an exact multiple of PARTS (elaboration error otherwise).
- PARTS, 4, number of parts per word; must be >= 2.
- MSB_FIRST, 0, 0: first part lands in bits [PART_W-1:0]; 1: first part lands in the top PART_W bits.
- Derived localparams: PART_W = WORD_W/PARTS; CNT_W = $clog2(PARTS+1).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  part available
- in_ready  output  1  part accepted when in_valid && in_ready
- in_data  input  PART_W  part payload
- in_last  input  1  accepted part is the final part of the current word
- out_valid  output  1  assembled word available
- out_ready  input  1  word consumed when out_valid && out_ready
- out_data  output  WORD_W  assembled word
- out_count  output  CNT_W  number of valid parts in out_data (1..PARTS)

Behaviour:
- Reset (rst high at a clock edge):
  - cnt = 0, accumulator = 0, out_valid = 0, out_data = 0, out_count = 0.
  - in_ready reads 0 while rst is high.
  - Reset mid-word discards the partial word and any held output word, with no emission.
- Accept: a part is accepted when in_valid && in_ready.
  - It is written into slot cnt of the accumulator. Slot k is bits [k*PART_W +: PART_W], or the mirrored slot when MSB_FIRST = 1.
  - cnt then increments.
- Completion: the accepted part completes the word when cnt == PARTS-1 or in_last == 1.
  - On the same edge, out_data <= accumulator merged with that part; unfilled slots are forced to 0.
  - out_count <= cnt+1, out_valid <= 1, and cnt and the accumulator clear to 0.
  - Latency: out_valid rises the cycle after the completing part is accepted.
- in_ready rules:
  - 1 when not in reset and cnt < PARTS-1.
  - At the final-slot position (cnt == PARTS-1), 1 only if out_valid == 0 or out_ready == 1.
  - A part carrying in_last at cnt < PARTS-1 is accepted only if the output slot is free or draining. Otherwise it is held off: in_ready = !out_valid || out_ready whenever in_last is asserted.
  - in_ready may depend combinationally on in_last and out_ready. It never depends on in_valid.
- Output register:
  - out_data and out_count are stable while out_valid && !out_ready.
  - out_valid drops the cycle after the handshake, unless a new word completes on that same edge, in which case it stays 1 with the new data (back-to-back, zero bubbles).
- Throughput: sustained one part per cycle, one word every PARTS cycles, with out_ready held high.
- Boundaries:
  - in_last on the first part: word with out_count = 1, only slot 0 nonzero.
  - in_last at cnt == PARTS-1: identical to normal completion.
  - Idle gaps (in_valid low) mid-word preserve cnt and the accumulator indefinitely.
  - cnt never exceeds PARTS-1.

Test Plan (WORD_W=32, PARTS=4, PART_W=8 unless noted):
1. LSB-first: parts 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready=1 -> one cycle after the 4th accept, out_data=0x44332211, out_count=4, out_valid for exactly 1 cycle.
2. MSB_FIRST=1, same parts -> out_data=0x11223344, out_count=4.
3. Early termination: parts 0xAA, 0xBB with in_last on 0xBB -> out_data=0x0000BBAA, out_count=2; next word restarts at slot 0.
4. Backpressure: out_ready=0, stream 8 parts 0x01..0x08 -> first word 0x04030201 held stable and in_ready drops at the 8th part. Raise out_ready -> 0x04030201 consumed, then 0x08070605 presented the next cycle; no part lost or duplicated.
5. Reset mid-word: accept 0x55, 0x66, assert rst one cycle, then send 0x01..0x04 -> only out_data=0x04030201 appears; out_valid=0 during and after reset until that completion.
6. Random in_valid/out_ready gaps with 1000 parts and random in_last -> scoreboard matches every word and out_count exactly.
